// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 Set-2 scan-code decoder with per-key held/press/release.
// Ports: clk, reset (sync, active-high), data_in[7:0], data_valid,
//   key_held/key_press/key_release[NUM_KEYS-1:0], any_held.
module ps2_key_decoder #(
  parameter int NUM_KEYS = 4,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES =
    {9'h01E, 9'h016, 9'h05A, 9'h029},
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          data_in,
  input  logic                data_valid,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_held
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic          is_e0, is_f0, is_aa, is_ign;
  logic          make_ev, brk_ev, clr_all;
  logic [8:0]    code;

  logic [NUM_KEYS-1:0] match;
  logic [NUM_KEYS-1:0] press_nxt, rel_nxt, held_nxt;

  assign is_e0  = (data_in == 8'hE0);
  assign is_f0  = (data_in == 8'hF0);
  assign is_aa  = (data_in == 8'hAA);
  assign is_ign = (data_in == 8'hFA) || (data_in == 8'hEE) ||
                  (data_in == 8'hFE) || (data_in == 8'h00) ||
                  (data_in == 8'hFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Timeout fires on the idle cycle that would bring the count
  // to TIMEOUT_CYCLES; a byte in that cycle is decoded instead.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (data_valid) begin
      cnt_nxt = '0;
      unique case (state)
        IDLE: begin
          if (is_e0)      state_nxt = EXT;
          else if (is_f0) state_nxt = BRK;
        end
        EXT: begin
          if (is_f0)      state_nxt = EXT_BRK;
          else if (!is_e0) state_nxt = IDLE;
        end
        BRK:     state_nxt = IDLE;
        EXT_BRK: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (cnt == TO_LAST) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_comb begin
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    clr_all = 1'b0;
    code    = {1'b0, data_in};
    if (data_valid) begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            is_aa:                 clr_all = 1'b1;
            is_e0, is_f0, is_ign:  make_ev = 1'b0;
            default:               make_ev = 1'b1;
          endcase
        end
        EXT: begin
          code    = {1'b1, data_in};
          make_ev = !is_e0 && !is_f0;
        end
        BRK: brk_ev = 1'b1;
        EXT_BRK: begin
          code   = {1'b1, data_in};
          brk_ev = 1'b1;
        end
        default: make_ev = 1'b0;
      endcase
    end
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      match[i] = (KEY_CODES[9*i +: 9] == code);
    end
  end

  assign press_nxt = {NUM_KEYS{make_ev}} & match & ~key_held;
  assign rel_nxt   = {NUM_KEYS{brk_ev}} & match & key_held;
  assign held_nxt  = clr_all ? '0 : ((key_held | press_nxt) & ~rel_nxt);

  always_ff @(posedge clk) begin
    if (reset) begin
      key_held    <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      key_held    <= held_nxt;
      key_press   <= press_nxt;
      key_release <= rel_nxt;
    end
  end

  assign any_held = |key_held;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed checks of ps2_key_decoder.
// Two instances: default codes with short timeout, and an E0-mapped key 0.
module tb_ps2_key_decoder;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;

  logic [3:0] held_a, press_a, rel_a;
  logic       any_a;
  logic [3:0] held_b, press_b, rel_b;
  logic       any_b;

  int n_vec = 0;
  int n_err = 0;

  ps2_key_decoder #(
    .NUM_KEYS(4),
    .KEY_CODES({9'h01E, 9'h016, 9'h05A, 9'h029}),
    .TIMEOUT_CYCLES(10)
  ) u_a (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .data_valid(data_valid),
    .key_held(held_a),
    .key_press(press_a),
    .key_release(rel_a),
    .any_held(any_a)
  );

  ps2_key_decoder #(
    .NUM_KEYS(4),
    .KEY_CODES({9'h01E, 9'h016, 9'h05A, 9'h15A}),
    .TIMEOUT_CYCLES(500000)
  ) u_b (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .data_valid(data_valid),
    .key_held(held_b),
    .key_press(press_b),
    .key_release(rel_b),
    .any_held(any_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte is sampled on the next rising edge; returns at the
  // following falling edge, where its effect is visible.
  task automatic send(input logic [7:0] b);
    data_in    = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    data_in    = 8'h29;
    data_valid = 1'b1;
    idle(2);
    reset      = 1'b0;
    data_valid = 1'b0;
    idle(1);

    chk("rst_held", held_a, 4'h0);
    chk("rst_press", press_a, 4'h0);
    chk("rst_rel", rel_a, 4'h0);
    chk("rst_any", any_a, 1'b0);
    chk("rst_held_b", held_b, 4'h0);

    send(8'h29);
    chk("s_press", press_a, 4'h1);
    chk("s_held", held_a, 4'h1);
    chk("s_any", any_a, 1'b1);
    idle(1);
    chk("s_press_1cyc", press_a, 4'h0);
    send(8'hF0);
    chk("s_f0_held", held_a, 4'h1);
    send(8'h29);
    chk("s_rel", rel_a, 4'h1);
    chk("s_rel_held", held_a, 4'h0);
    chk("s_rel_any", any_a, 1'b0);
    idle(1);
    chk("s_rel_1cyc", rel_a, 4'h0);

    send(8'h5A);
    chk("t_press1", press_a, 4'h2);
    chk("t_b_noext", press_b, 4'h2);
    send(8'h5A);
    chk("t_press2", press_a, 4'h0);
    chk("t_held2", held_a, 4'h2);
    send(8'h5A);
    chk("t_press3", press_a, 4'h0);
    chk("t_held3", held_a, 4'h2);
    send(8'hF0);
    send(8'h5A);
    chk("t_rel", rel_a, 4'h2);
    chk("t_held0", held_a, 4'h0);
    chk("t_held0_b", held_b, 4'h0);

    send(8'h16);
    chk("o_held_4", held_a, 4'h4);
    send(8'h1E);
    chk("o_held_c", held_a, 4'hC);
    send(8'hF0);
    send(8'h16);
    chk("o_held_8", held_a, 4'h8);
    chk("o_rel_4", rel_a, 4'h4);
    send(8'hF0);
    send(8'h1E);
    chk("o_held_0", held_a, 4'h0);
    chk("o_any_0", any_a, 1'b0);
    send(8'hFA);
    send(8'h00);
    send(8'hFF);
    chk("ign_held", held_a, 4'h0);
    chk("ign_press", press_a, 4'h0);

    send(8'hE0);
    send(8'h5A);
    chk("x_press_b", press_b, 4'h1);
    chk("x_held_b", held_b, 4'h1);
    chk("x_held_a", held_a, 4'h0);
    send(8'hE0);
    send(8'hF0);
    send(8'h5A);
    chk("x_rel_b", rel_b, 4'h1);
    chk("x_rel_held_b", held_b, 4'h0);
    send(8'hE0);
    send(8'hE0);
    send(8'h5A);
    chk("x_ee_press_b", press_b, 4'h1);
    chk("x_ee_held_b", held_b, 4'h1);
    send(8'hE0);
    send(8'hF0);
    send(8'h5A);
    chk("x_clean_b", held_b, 4'h0);

    send(8'hF0);
    idle(10);
    send(8'h29);
    chk("to_make_press", press_a, 4'h1);
    chk("to_make_rel", rel_a, 4'h0);
    chk("to_make_held", held_a, 4'h1);
    send(8'hF0);
    idle(9);
    send(8'h29);
    chk("to_brk_rel", rel_a, 4'h1);
    chk("to_brk_held", held_a, 4'h0);

    send(8'h29);
    send(8'h1E);
    chk("aa_pre_held", held_a, 4'h9);
    send(8'hAA);
    chk("aa_held", held_a, 4'h0);
    chk("aa_rel", rel_a, 4'h0);
    chk("aa_any", any_a, 1'b0);

    send(8'hF0);
    reset      = 1'b1;
    data_in    = 8'h1E;
    data_valid = 1'b1;
    idle(1);
    reset      = 1'b0;
    data_valid = 1'b0;
    chk("rm_held", held_a, 4'h0);
    chk("rm_press", press_a, 4'h0);
    send(8'h29);
    chk("rm_make_press", press_a, 4'h1);
    chk("rm_make_rel", rel_a, 4'h0);
    chk("rm_make_held", held_a, 4'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised PS/2 Set-2 scan-code decoder between the PS/2 receiver and game/benchmark control logic. It consumes one received byte per `data_valid` strobe in the system clock domain and tracks make, break and extended (E0) sequences. For each of `NUM_KEYS` configured keys it produces a held level plus one-cycle press and release pulses. Keys are tracked independently, typematic repeats are suppressed, and a stalled prefix sequence recovers by timeout.

## Interface
Parameters:
- `NUM_KEYS`, default 4: number of tracked keys (1..32).
- `KEY_CODES`, default {9'h01E, 9'h016, 9'h05A, 9'h029}: packed `9*NUM_KEYS` bits. Key i is `KEY_CODES[9*i +: 9]`. Bit 8 is the extended (E0) flag; bits 7:0 are the scan code. The default maps 0=space, 1=enter, 2='1', 3='2'.
- `TIMEOUT_CYCLES`, default 500000: idle clocks allowed inside a prefix sequence before abandoning it (must be at least 1).

Ports:
- `clk`, in, 1: system clock; all logic on the rising edge.
- `reset`, in, 1: reset, synchronous, active-high.
- `data_in`, in, 8: received byte; valid only when `data_valid` is high.
- `data_valid`, in, 1: one-cycle strobe per byte. Back-to-back high cycles are consecutive bytes.
- `key_held`, out, `NUM_KEYS`: bit i is high while key i is down.
- `key_press`, out, `NUM_KEYS`: one-cycle pulse on key i's first make.
- `key_release`, out, `NUM_KEYS`: one-cycle pulse on key i's break while it is held.
- `any_held`, out, 1: OR of `key_held`.

## Operation
State machine states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Transitions occur only on a cycle with `data_valid` high, except timeout.

Byte handling per state:
- IDLE:
  - E0: go to EXT.
  - F0: go to BRK.
  - AA (keyboard self-test pass / hot-plug): clear all `key_held` with no release pulses; stay in IDLE.
  - FA, EE, FE, 00, FF: ignored; stay in IDLE.
  - Any other byte b: make event on code {0,b}; stay in IDLE.
- EXT:
  - F0: go to EXT_BRK.
  - E0: stay in EXT and restart the timeout counter.
  - Any other byte b: make event on {1,b}; go to IDLE.
- BRK: any byte b produces a break event on {0,b}; go to IDLE.
- EXT_BRK: any byte b produces a break event on {1,b}; go to IDLE.

Event rules:
- Make event: for every i with `KEY_CODES[i]` equal to the code and `key_held[i]` low, set `key_held[i]` and pulse `key_press[i]`. If `key_held[i]` is already high (typematic repeat), there is no change and no pulse.
- Break event: for every matching i with `key_held[i]` high, clear it and pulse `key_release[i]`. A break for an unheld or unmapped key does nothing.
- Duplicate entries in `KEY_CODES`: all matching indices act identically.
- A break affects only its own key. Other held keys are unchanged.
- Unmapped codes only advance the state machine.

Timeout:
- Counter width is $clog2(TIMEOUT_CYCLES+1).
- The counter is zero in IDLE and cleared on every accepted byte.
- In any non-IDLE state it increments on each cycle with `data_valid` low.
- When it reaches `TIMEOUT_CYCLES`, return to IDLE and clear the counter. No event is generated and `key_held` is unchanged.

## Timing
- Reset values: `key_held`=0, `key_press`=0, `key_release`=0, `any_held`=0, state IDLE, counter 0.
- Reset dominates: a byte strobed during reset is dropped.
- Reset applied mid-sequence (e.g. after F0) discards the prefix.
- Latency: `key_held`, `key_press` and `key_release` update on the clock edge that samples `data_valid`, so they are visible the cycle after the strobe. Pulses are exactly one cycle wide.
- `any_held` is combinational from registered `key_held`; no extra latency.
- One byte is accepted per cycle with no backpressure. Full-rate strobes must decode correctly.
- A timeout and a byte arriving in the same cycle: the byte wins and is decoded in the current state.
- Press and release of the same key can never pulse in the same cycle.

## Test plan
- Single press and release: reset, then 29, then F0 29. Expect `key_press`[0] for one cycle after 29, `key_held`=0001, `any_held`=1. After the second 29, `key_release`[0] pulses and `key_held`=0000.
- Typematic suppression: send 5A, 5A, 5A, then F0 5A. Expect exactly one `key_press`[1], `key_held`[1] high throughout, and one `key_release`[1].
- Overlapping keys: send 16, 1E, F0 16. Expect `key_held` 0100 → 1100 → 1000. Then F0 1E gives `key_held`=0000 and `any_held`=0.
- Extended distinction: set `KEY_CODES`[0]=9'h15A. Send 5A: no event for key 0. Send E0 5A: key 0 press. Send E0 F0 5A: key 0 release. Send E0 E0 5A: key 0 press.
- Timeout recovery: with `TIMEOUT_CYCLES`=10, send F0 and then idle 10 cycles; the state returns to IDLE. A following 29 is a make (press pulse), not a break. Idling 9 cycles then sending 29 is a break.
- Reset and AA: hold keys 0 and 3, then send AA. Expect `key_held`=0000 with no release pulses. Pulse `reset` one cycle between F0 and 29: expect 29 treated as a make.
